// File: rtl/emergency_dispatch_arbiter.sv
// emergency_dispatch_arbiter: shares one outbound help-call link between
// N_ZONES alarm zones with round-robin grant, retries and per-zone outcome.
// Ports: clk, reset_n (sync, active-low); zone_req/zone_danger per zone in;
//   link_ack/link_fail pulses in; call_start pulse, call_zone, call_active,
//   zone_served, zone_fault out (all registered).
// Option: DISPATCH_DANGER_PRIORITY_EN gives danger-flagged zones precedence
//   in arbitration; undefined means plain round-robin.
module emergency_dispatch_arbiter #(
  parameter int N_ZONES      = 4,
  parameter int CALL_TIMEOUT = 250_000_000,
  parameter int GUARD_TIME   = 50_000_000,
  parameter int MAX_RETRIES  = 3,
  localparam int ZW = $clog2(N_ZONES)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_ZONES-1:0] zone_req,
  input  logic [N_ZONES-1:0] zone_danger,
  input  logic               link_ack,
  input  logic               link_fail,
  output logic               call_start,
  output logic [ZW-1:0]      call_zone,
  output logic               call_active,
  output logic [N_ZONES-1:0] zone_served,
  output logic [N_ZONES-1:0] zone_fault
);

  localparam int WW = $clog2(CALL_TIMEOUT + 1);
  localparam int GW = $clog2(GUARD_TIME + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_DIAL,
    S_WAIT,
    S_GUARD
  } state_t;

  state_t             r_state;
  logic               r_call_start;
  logic [ZW-1:0]      r_call_zone;
  logic               r_call_active;
  logic [N_ZONES-1:0] r_zone_served;
  logic [N_ZONES-1:0] r_zone_fault;
  logic [ZW-1:0]      r_rr_ptr;
  logic [3:0]         r_retry_cnt;
  logic               r_retry_pend;
  logic [WW-1:0]      r_wait_cnt;
  logic [GW-1:0]      r_guard_cnt;

  logic [N_ZONES-1:0] w_eligible;
  logic [N_ZONES-1:0] w_cand;
  logic               w_found;
  logic [ZW-1:0]      w_winner;
  logic [ZW-1:0]      w_next_ptr;
  logic [N_ZONES-1:0] w_zone_oh;
  logic               w_in_wait;
  logic               w_timeout;
  logic               w_ack;
  logic               w_fail;
  logic [3:0]         w_retry_inc;
  logic               w_give_up;
  logic [N_ZONES-1:0] w_set_served;
  logic [N_ZONES-1:0] w_set_fault;
  logic               w_guard_done;

  assign w_eligible = zone_req & ~r_zone_served & ~r_zone_fault;

`ifdef DISPATCH_DANGER_PRIORITY_EN
  logic [N_ZONES-1:0] w_dang;
  assign w_dang = w_eligible & zone_danger;
  assign w_cand = (|w_dang) ? w_dang : w_eligible;
`else
  logic w_unused_danger;
  assign w_unused_danger = ^zone_danger;
  assign w_cand = w_eligible;
`endif

  // First candidate at or after rr_ptr, wrapping modulo N_ZONES.
  always_comb begin
    logic [ZW:0]   w_j;
    logic [ZW-1:0] w_idx;
    w_found  = 1'b0;
    w_winner = '0;
    w_j      = '0;
    w_idx    = '0;
    for (int k = 0; k < N_ZONES; k++) begin
      w_j = {1'b0, r_rr_ptr} + (ZW+1)'(k);
      if (w_j >= (ZW+1)'(N_ZONES))
        w_j = w_j - (ZW+1)'(N_ZONES);
      w_idx = w_j[ZW-1:0];
      if (!w_found && w_cand[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_next_ptr = (r_call_zone == ZW'(N_ZONES-1)) ?
                      '0 : r_call_zone + 1'b1;
  assign w_zone_oh  = N_ZONES'(1) << r_call_zone;

  // Ack has precedence over a simultaneous fail or the timeout cycle.
  assign w_in_wait   = (r_state == S_WAIT);
  assign w_timeout   = (r_wait_cnt == WW'(CALL_TIMEOUT-1));
  assign w_ack       = w_in_wait & link_ack;
  assign w_fail      = w_in_wait & ~link_ack & (link_fail | w_timeout);
  assign w_retry_inc = r_retry_cnt + 4'd1;
  assign w_give_up   = (w_retry_inc >= 4'(MAX_RETRIES));

  assign w_set_served = w_ack ? (w_zone_oh & zone_req) : '0;
  assign w_set_fault  = (w_fail && w_give_up) ? w_zone_oh : '0;
  assign w_guard_done = (r_guard_cnt == GW'(GUARD_TIME-1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_call_start  <= 1'b0;
      r_call_zone   <= '0;
      r_call_active <= 1'b0;
      r_zone_served <= '0;
      r_zone_fault  <= '0;
      r_rr_ptr      <= '0;
      r_retry_cnt   <= '0;
      r_retry_pend  <= 1'b0;
      r_wait_cnt    <= '0;
      r_guard_cnt   <= '0;
    end else begin
      r_call_start  <= 1'b0;
      // A dropped request wipes that zone's outcome in any state.
      r_zone_served <= (r_zone_served | w_set_served) & zone_req;
      r_zone_fault  <= (r_zone_fault | w_set_fault) & zone_req;

      unique case (r_state)
        S_IDLE: begin
          if (|w_eligible)
            r_state <= S_ARB;
        end
        S_ARB: begin
          if (w_found) begin
            r_call_zone <= w_winner;
            r_retry_cnt <= '0;
            r_state     <= S_DIAL;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_DIAL: begin
          r_call_start  <= 1'b1;
          r_call_active <= 1'b1;
          r_wait_cnt    <= '0;
          r_state       <= S_WAIT;
        end
        S_WAIT: begin
          if (w_ack) begin
            r_rr_ptr      <= w_next_ptr;
            r_retry_pend  <= 1'b0;
            r_call_active <= 1'b0;
            r_guard_cnt   <= '0;
            r_state       <= S_GUARD;
          end else if (w_fail) begin
            r_retry_cnt   <= w_retry_inc;
            r_call_active <= 1'b0;
            r_guard_cnt   <= '0;
            r_state       <= S_GUARD;
            if (w_give_up) begin
              r_rr_ptr     <= w_next_ptr;
              r_retry_pend <= 1'b0;
            end else begin
              r_retry_pend <= 1'b1;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_GUARD: begin
          // Losing the request during hold-off abandons the retry.
          if (!zone_req[r_call_zone])
            r_retry_pend <= 1'b0;
          if (w_guard_done) begin
            if (r_retry_pend && zone_req[r_call_zone])
              r_state <= S_DIAL;
            else
              r_state <= S_ARB;
            r_retry_pend <= 1'b0;
          end else begin
            r_guard_cnt <= r_guard_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign call_start  = r_call_start;
  assign call_zone   = r_call_zone;
  assign call_active = r_call_active;
  assign zone_served = r_zone_served;
  assign zone_fault  = r_zone_fault;

endmodule

// File: tb/tb_emergency_dispatch_arbiter.sv
// tb_emergency_dispatch_arbiter: randomized calls against a
// transaction-level model of zone outcomes, grant order and call timing.
module tb_emergency_dispatch_arbiter;

  localparam int N  = 4;
  localparam int CT = 20;
  localparam int GT = 4;
  localparam int MR = 3;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] zone_req;
  logic [N-1:0] zone_danger;
  logic         link_ack;
  logic         link_fail;
  logic         call_start;
  logic [1:0]   call_zone;
  logic         call_active;
  logic [N-1:0] zone_served;
  logic [N-1:0] zone_fault;

  int n_chk  = 0;
  int n_pass = 0;

  // Model state: outcomes, round-robin origin, pending retry.
  logic [N-1:0] m_req;
  logic [N-1:0] m_dng;
  logic [N-1:0] m_srv;
  logic [N-1:0] m_flt;
  int           m_rr;
  int           m_pz;
  int           m_rcnt;
  bit           m_pend;

  emergency_dispatch_arbiter #(
    .N_ZONES      (N),
    .CALL_TIMEOUT (CT),
    .GUARD_TIME   (GT),
    .MAX_RETRIES  (MR)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .zone_req    (zone_req),
    .zone_danger (zone_danger),
    .link_ack    (link_ack),
    .link_fail   (link_fail),
    .call_start  (call_start),
    .call_zone   (call_zone),
    .call_active (call_active),
    .zone_served (zone_served),
    .zone_fault  (zone_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int pick();
    logic [N-1:0] cand;
    cand = m_req & ~m_srv & ~m_flt;
`ifdef DISPATCH_DANGER_PRIORITY_EN
    if ((cand & m_dng) != 0) cand = cand & m_dng;
`endif
    for (int k = 0; k < N; k++) begin
      int z;
      z = (m_rr + k) % N;
      if (cand[z]) return z;
    end
    return -1;
  endfunction

  task automatic model_reset(input logic [N-1:0] req,
                             input logic [N-1:0] dng);
    m_req  = req;
    m_dng  = dng;
    m_srv  = '0;
    m_flt  = '0;
    m_rr   = 0;
    m_pz   = 0;
    m_rcnt = 0;
    m_pend = 0;
  endtask

  task automatic noise();
    link_ack  = 1'b0;
    link_fail = 1'b0;
    if ($urandom_range(3) == 0) begin
      link_ack  = 1'($urandom_range(1));
      link_fail = ~link_ack;
    end
  endtask

  // Count negedges until call_start shows; stray link pulses meanwhile
  // land outside WAIT and must be ignored.
  task automatic wait_start(input int gap, output bit ok);
    int k;
    k  = 0;
    ok = 0;
    while (k < 200) begin
      @(negedge clk);
      link_ack  = 1'b0;
      link_fail = 1'b0;
      k++;
      if (call_start) begin
        ok = 1;
        break;
      end
      noise();
    end
    chk("start_gap", k, gap);
  endtask

  task automatic expect_quiet(input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (call_start) seen++;
      noise();
    end
    @(negedge clk);
    link_ack  = 1'b0;
    link_fail = 1'b0;
    chk("no_call", seen, 0);
  endtask

  // mode: 0 random, 1 ack, 2 fail, 3 timeout
  task automatic serve(input int z, input int mode);
    int kind;
    int d;
    int k;
    chk("call_zone", call_zone, z);
    chk("active_up", call_active, 1);
    kind = (mode == 0) ? int'($urandom_range(2)) : mode - 1;
    if (kind == 2) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (call_active && k < 100);
      chk("wait_len", k, CT);
    end else begin
      d = $urandom_range(CT, 1);
      repeat (d - 1) @(negedge clk);
      if (kind == 0) begin
        link_ack  = 1'b1;
        link_fail = 1'($urandom_range(1));
      end else begin
        link_fail = 1'b1;
      end
      @(negedge clk);
      link_ack  = 1'b0;
      link_fail = 1'b0;
      chk("active_drop", call_active, 0);
    end
    chk("start_pulse", call_start, 0);
    if (kind == 0) begin
      if (m_req[z]) m_srv[z] = 1'b1;
      m_rr   = (z + 1) % N;
      m_pend = 0;
    end else begin
      m_rcnt++;
      if (m_rcnt < MR) begin
        m_pend = 1;
        m_pz   = z;
      end else begin
        m_flt[z] = 1'b1;
        m_rr     = (z + 1) % N;
        m_pend   = 0;
      end
    end
    chk("served", zone_served, m_srv);
    chk("fault", zone_fault, m_flt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    zone_req  = '0;
    link_ack  = 1'b0;
    link_fail = 1'b0;
    @(negedge clk);
    chk("rst_outs", {call_start, call_active, call_zone,
                     zone_served, zone_fault}, 0);
  endtask

  task automatic scenario(input logic [N-1:0] req,
                          input logic [N-1:0] dng,
                          input int mode);
    int gap;
    int z;
    bit ok;
    do_reset();
    zone_danger = dng;
    reset_n     = 1'b1;
    zone_req    = req;
    model_reset(req, dng);
    gap = 3;
    for (int c = 0; c < 40; c++) begin
      if (m_pend) begin
        z = m_pz;
      end else begin
        z      = pick();
        m_rcnt = 0;
      end
      if (z < 0) break;
      wait_start(gap, ok);
      if (!ok) return;
      serve(z, mode);
      gap = m_pend ? GT + 1 : GT + 2;
    end
    expect_quiet(3 * GT + 10);
  endtask

  initial begin
    bit ok;
    reset_n     = 1'b0;
    zone_req    = '0;
    zone_danger = '0;
    link_ack    = 1'b0;
    link_fail   = 1'b0;
    repeat (2) @(negedge clk);

    // Single zone, plain served call; dropping req clears served.
    scenario(4'b0001, 4'b0000, 1);
    zone_req = '0;
    @(negedge clk);
    chk("served_clr", zone_served, 0);

    // All zones: grant order 0,1,2,3.
    scenario(4'b1111, 4'b0000, 1);

    // Every attempt fails: three dials then fault; drop clears it.
    scenario(4'b0100, 4'b0000, 2);
    zone_req = '0;
    @(negedge clk);
    chk("fault_clr", zone_fault, 0);

    // Silent link: each attempt ends on timeout.
    scenario(4'b0010, 4'b0000, 3);

    // Danger flag on zone 1 with rr origin at 0.
    scenario(4'b0011, 4'b0010, 1);

    // Reset in the middle of the second call.
    do_reset();
    zone_danger = '0;
    reset_n     = 1'b1;
    zone_req    = 4'b0011;
    model_reset(4'b0011, 4'b0000);
    wait_start(3, ok);
    if (ok) begin
      serve(0, 1);
      wait_start(GT + 2, ok);
      chk("mid_zone", call_zone, 1);
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      chk("mid_rst", {call_start, call_active, call_zone,
                      zone_served, zone_fault}, 0);
      reset_n = 1'b1;
      wait_start(3, ok);
      chk("redial_zone", call_zone, 0);
    end

    for (int s = 0; s < 25; s++)
      scenario(N'($urandom_range(15, 1)), N'($urandom_range(15)), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
